// File: rtl/fib_bus_arbiter_if.sv
// Requester-side bundle of the fib bus arbiter: per-requester request fields
// plus the shared grant/completion/read-data returns.
interface fib_bus_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [2*NUM_REQ-1:0] op;
    logic [NUM_REQ-1:0]   addr;
    logic [8*NUM_REQ-1:0] wdata;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic                 err;
    logic [7:0]           rdata;

    modport master (output req, op, addr, wdata, input gnt, done, err, rdata);
    modport slave  (input req, op, addr, wdata, output gnt, done, err, rdata);
endinterface

// File: rtl/fib_bus_arbiter.sv
// Serialises register reads/writes and fib runs from NUM_REQ requesters onto one
// fib engine bus. FIB_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
//
// state   | meaning
// IDLE    | waiting for a request while the engine is not busy
// ACCESS  | one-cycle bus strobe (oe / we + drive / start / none)
// WAIT_HI | start issued, waiting up to 2 cycles for busy to rise
// WAIT_LO | run in progress, waiting for busy to fall
// RESP    | done pulse to the winner, grant released afterwards
module fib_bus_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic             clk,
    input  logic             reset,
    fib_bus_arbiter_if.slave rq,
    inout  wire  [7:0]       data,
    output logic             address,
    output logic             we,
    output logic             oe,
    output logic             start,
    input  logic             busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_ST = 2'b10;

    typedef enum logic [2:0] {IDLE, ACCESS, WAIT_HI, WAIT_LO, RESP} state_t;

    state_t               state, state_nxt;
    logic [1:0]           op_q, op_nxt;
    logic                 addr_q, addr_nxt;
    logic [7:0]           wdata_q, wdata_nxt;
    logic [NUM_REQ-1:0]   gnt_q, gnt_nxt;
    logic [NUM_REQ-1:0]   done_q, done_nxt;
    logic                 err_q, err_nxt;
    logic [7:0]           rdata_q, rdata_nxt;
    logic                 address_nxt, we_nxt, oe_nxt, start_nxt;
    logic                 drive_q, drive_nxt;
    logic                 wait_cnt, wait_cnt_nxt;
    logic                 found;
    logic [IDX_W-1:0]     sel;
    logic [1:0]           sel_op;
    logic                 sel_addr;
    logic [7:0]           sel_wdata;

`ifdef FIB_ARB_ROUND_ROBIN_EN
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W:0]   rr_idx;

    always_comb begin
        found  = 1'b0;
        sel    = '0;
        rr_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_idx = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (rr_idx >= NUM_REQ_W) rr_idx = rr_idx - NUM_REQ_W;
            if (!found && rq.req[rr_idx[IDX_W-1:0]]) begin
                found = 1'b1;
                sel   = rr_idx[IDX_W-1:0];
            end
        end
    end

    // Pointer holds the first index to search next time, i.e. last winner + 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (state == IDLE && state_nxt == ACCESS) begin
            rr_ptr <= (sel == LAST_IDX) ? '0 : sel + IDX_W'(1);
        end
    end
`else
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rq.req[i]) begin
                found = 1'b1;
                sel   = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        sel_op    = OP_RD;
        sel_addr  = 1'b0;
        sel_wdata = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == IDX_W'(i)) begin
                sel_op    = rq.op[2*i +: 2];
                sel_addr  = rq.addr[i];
                sel_wdata = rq.wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        op_nxt       = op_q;
        addr_nxt     = addr_q;
        wdata_nxt    = wdata_q;
        gnt_nxt      = gnt_q;
        done_nxt     = '0;
        err_nxt      = 1'b0;
        rdata_nxt    = rdata_q;
        address_nxt  = address;
        we_nxt       = 1'b0;
        oe_nxt       = 1'b0;
        start_nxt    = 1'b0;
        drive_nxt    = 1'b0;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (!busy && found) begin
                    op_nxt       = sel_op;
                    addr_nxt     = sel_addr;
                    wdata_nxt    = sel_wdata;
                    gnt_nxt      = '0;
                    gnt_nxt[sel] = 1'b1;
                    address_nxt  = sel_addr;
                    oe_nxt       = (sel_op == OP_RD);
                    we_nxt       = (sel_op == OP_WR);
                    drive_nxt    = (sel_op == OP_WR);
                    start_nxt    = (sel_op == OP_ST);
                    state_nxt    = ACCESS;
                end
            end
            ACCESS: begin
                if (op_q == OP_ST) begin
                    wait_cnt_nxt = 1'b1;
                    state_nxt    = WAIT_HI;
                end else begin
                    if (op_q == OP_RD) rdata_nxt = data;
                    err_nxt   = (op_q != OP_RD) && (op_q != OP_WR);
                    done_nxt  = gnt_q;
                    state_nxt = RESP;
                end
            end
            WAIT_HI: begin
                if (busy) begin
                    state_nxt = WAIT_LO;
                end else if (wait_cnt == 1'b0) begin
                    done_nxt  = gnt_q;
                    state_nxt = RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt - 1'b1;
                end
            end
            WAIT_LO: begin
                if (!busy) begin
                    done_nxt  = gnt_q;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            op_q     <= OP_RD;
            addr_q   <= 1'b0;
            wdata_q  <= 8'h00;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= 8'h00;
            address  <= 1'b0;
            we       <= 1'b0;
            oe       <= 1'b0;
            start    <= 1'b0;
            drive_q  <= 1'b0;
            wait_cnt <= 1'b0;
        end else begin
            state    <= state_nxt;
            op_q     <= op_nxt;
            addr_q   <= addr_nxt;
            wdata_q  <= wdata_nxt;
            gnt_q    <= gnt_nxt;
            done_q   <= done_nxt;
            err_q    <= err_nxt;
            rdata_q  <= rdata_nxt;
            address  <= address_nxt;
            we       <= we_nxt;
            oe       <= oe_nxt;
            start    <= start_nxt;
            drive_q  <= drive_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Drive enable is a flop, so reset releases the bus asynchronously.
    assign data     = drive_q ? wdata_q : 8'hzz;
    assign rq.gnt   = gnt_q;
    assign rq.done  = done_q;
    assign rq.err   = err_q;
    assign rq.rdata = rdata_q;
endmodule

// File: tb/tb_fib_bus_arbiter.sv
// Directed bench for fib_bus_arbiter with a small behavioural fib engine on the bus.
module tb_fib_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ext_busy = 1'b0;
    logic ignore_start = 1'b0;
    logic eng_busy = 1'b0;
    logic [7:0] eng_a = 8'h00;
    logic [7:0] eng_b = 8'h00;
    wire  [7:0] fib_data;
    wire        fib_address, fib_we, fib_oe, fib_start;
    wire        busy = eng_busy | ext_busy;
    wire  [8:0] eng_sum = {1'b0, eng_a} + {1'b0, eng_b};

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0, we_cnt = 0, oe_cnt = 0, busy_cnt = 0;
    logic [7:0] we_data = 8'h00;
    logic       we_addr = 1'b0;
    logic       oe_addr = 1'b0;

    fib_bus_arbiter_if #(.NUM_REQ(2)) rq ();

    fib_bus_arbiter #(.NUM_REQ(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .rq      (rq),
        .data    (fib_data),
        .address (fib_address),
        .we      (fib_we),
        .oe      (fib_oe),
        .start   (fib_start),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Engine: writes on we, drives on oe, runs (a,b)<=(b,a+b) until the sum overflows.
    assign fib_data = (fib_oe && !fib_we) ? (fib_address ? eng_b : eng_a) : 8'hzz;

    always @(posedge clk) begin
        if (fib_we) begin
            if (fib_address) eng_b <= fib_data;
            else             eng_a <= fib_data;
        end
        if (eng_busy) begin
            eng_a <= eng_b;
            eng_b <= eng_sum[7:0];
            if (eng_sum[8]) eng_busy <= 1'b0;
        end else if (fib_start && !ignore_start) begin
            eng_busy <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (fib_start) start_cnt++;
        if (fib_we) begin
            we_cnt++;
            we_data = fib_data;
            we_addr = fib_address;
        end
        if (fib_oe) begin
            oe_cnt++;
            oe_addr = fib_address;
        end
        if (eng_busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_req(input int idx, input logic [1:0] op, input logic a, input logic [7:0] wd);
        @(negedge clk);
        rq.req[idx]          = 1'b1;
        rq.op[2*idx +: 2]    = op;
        rq.addr[idx]         = a;
        rq.wdata[8*idx +: 8] = wd;
    endtask

    task automatic wait_done(input int idx, output int lat, output logic [7:0] rd, output logic er);
        lat = -1;
        rd  = 8'h00;
        er  = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (rq.done[idx]) begin
                lat = k;
                rd  = rq.rdata;
                er  = rq.err;
                break;
            end
        end
        @(negedge clk);
        rq.req[idx] = 1'b0;
        if (lat < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input int idx, input logic [1:0] op, input logic a, input logic [7:0] wd,
                         output int lat, output logic [7:0] rd, output logic er);
        start_req(idx, op, a, wd);
        wait_done(idx, lat, rd, er);
    endtask

    initial begin
        int lat;
        logic [7:0] rd;
        logic er;
        int s0, w0, o0, b0, wins;

        rq.req = '0; rq.op = '0; rq.addr = '0; rq.wdata = '0;
        #2 reset = 1'b0;
        #1;
        check("rst_gnt", 32'(rq.gnt), 32'd0);
        check("rst_done", 32'(rq.done), 32'd0);
        check("rst_err", 32'(rq.err), 32'd0);
        check("rst_rdata", 32'(rq.rdata), 32'd0);
        check("rst_strobes", {28'd0, fib_address, fib_we, fib_oe, fib_start}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Both requesters read continuously; observe four winners.
        @(negedge clk);
        rq.req = 2'b11;
        wins = 0;
        for (int k = 0; k < 60 && wins < 4; k++) begin
            @(posedge clk);
            #1;
            if (rq.done != 2'b00) begin
                check("arb_gnt_eq_done", 32'(rq.gnt), 32'(rq.done));
`ifdef FIB_ARB_ROUND_ROBIN_EN
                check("arb_winner", 32'(rq.done), (wins % 2 == 0) ? 32'd1 : 32'd2);
`else
                check("arb_winner", 32'(rq.done), 32'd1);
`endif
                wins++;
            end
        end
        check("arb_wins", 32'(wins), 32'd4);
        @(negedge clk);
        rq.req = 2'b00;
        repeat (2) @(posedge clk);

        // Write then read back through a different requester.
        w0 = we_cnt; o0 = oe_cnt;
        do_op(0, 2'b01, 1'b0, 8'h05, lat, rd, er);
        check("wr_lat", 32'(lat), 32'd2);
        check("wr_we_cycles", 32'(we_cnt - w0), 32'd1);
        check("wr_bus_data", 32'(we_data), 32'h05);
        check("wr_oe_cycles", 32'(oe_cnt - o0), 32'd0);
        w0 = we_cnt;
        do_op(1, 2'b00, 1'b0, 8'hAA, lat, rd, er);
        check("rd_lat", 32'(lat), 32'd2);
        check("rd_data", 32'(rd), 32'h05);
        check("rd_no_we", 32'(we_cnt - w0), 32'd0);
        check("rd_err", 32'(er), 32'd0);

        // Seed A=B=1, run, read back the last pair before overflow.
        do_op(0, 2'b01, 1'b0, 8'h01, lat, rd, er);
        do_op(0, 2'b01, 1'b1, 8'h01, lat, rd, er);
        check("wr_b_addr", 32'(we_addr), 32'd1);
        s0 = start_cnt; b0 = busy_cnt;
        do_op(1, 2'b10, 1'b0, 8'h00, lat, rd, er);
        check("run_start_cycles", 32'(start_cnt - s0), 32'd1);
        check("run_busy_cycles", 32'(busy_cnt - b0), 32'd12);
        check("run_lat", 32'(lat), 32'd15);
        check("run_busy_at_done", 32'(eng_busy), 32'd0);
        do_op(0, 2'b00, 1'b0, 8'h00, lat, rd, er);
        check("run_a", 32'(rd), 32'hE9);
        do_op(1, 2'b00, 1'b1, 8'h00, lat, rd, er);
        check("run_b", 32'(rd), 32'h79);
        check("rd_b_addr", 32'(oe_addr), 32'd1);

        // Engine ignores start: WAIT_HI gives up after two cycles.
        ignore_start = 1'b1;
        s0 = start_cnt;
        do_op(0, 2'b10, 1'b0, 8'h00, lat, rd, er);
        check("ign_lat", 32'(lat), 32'd4);
        check("ign_start_cycles", 32'(start_cnt - s0), 32'd1);
        ignore_start = 1'b0;

        // Externally busy engine blocks any grant.
        @(negedge clk);
        ext_busy = 1'b1;
        s0 = start_cnt; w0 = we_cnt; o0 = oe_cnt;
        start_req(0, 2'b00, 1'b1, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        check("busy_no_gnt", 32'(rq.gnt), 32'd0);
        check("busy_no_strobe", 32'((start_cnt - s0) + (we_cnt - w0) + (oe_cnt - o0)), 32'd0);
        @(negedge clk);
        ext_busy = 1'b0;
        wait_done(0, lat, rd, er);
        check("busy_rel_lat", 32'(lat), 32'd2);
        check("busy_rel_data", 32'(rd), 32'h79);

        // Reserved opcode: done + err, no strobes.
        s0 = start_cnt; w0 = we_cnt; o0 = oe_cnt;
        do_op(1, 2'b11, 1'b0, 8'h33, lat, rd, er);
        check("rsv_lat", 32'(lat), 32'd2);
        check("rsv_err", 32'(er), 32'd1);
        check("rsv_no_strobe", 32'((start_cnt - s0) + (we_cnt - w0) + (oe_cnt - o0)), 32'd0);
        @(posedge clk);
        #1;
        check("rsv_err_pulse", 32'(rq.err), 32'd0);

        // Reset during WAIT_LO.
        do_op(0, 2'b01, 1'b0, 8'h01, lat, rd, er);
        do_op(0, 2'b01, 1'b1, 8'h01, lat, rd, er);
        start_req(0, 2'b10, 1'b0, 8'h00);
        for (int k = 0; k < 20 && !eng_busy; k++) @(posedge clk);
        check("mid_busy_seen", 32'(eng_busy), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(rq.gnt), 32'd0);
        check("mid_rst_done", 32'(rq.done), 32'd0);
        check("mid_rst_strobes", {29'd0, fib_we, fib_oe, fib_start}, 32'd0);
        rq.req = 2'b00;
        for (int k = 0; k < 40 && eng_busy; k++) @(posedge clk);
        check("mid_engine_idle", 32'(eng_busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_no_stale_done", 32'(rq.done), 32'd0);
        do_op(0, 2'b00, 1'b0, 8'h00, lat, rd, er);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_a", 32'(rd), 32'hE9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
